// File: rtl/header_capture_filter_pkg.sv
// header_capture_filter_pkg: dispatcher state encodings, block defaults and the shadowed match config record
package header_capture_filter_pkg;
    localparam int COUNT_META_DATA_MAX_DEF = 5;
    localparam int STATE_WIDTH_DEF = 3;

    typedef enum logic [STATE_WIDTH_DEF-1:0] {
        IDLE               = 3'd0,
        PARSE_DATA         = 3'd1,
        CONTROL            = 3'd2,
        SEND_ANALYSED_DATA = 3'd3,
        SEND_REMAIN        = 3'd4,
        DROP               = 3'd5
    } dp_state_t;

    typedef struct packed {
        logic        enable;
        logic        drop_on_match;
        logic [15:0] value;
        logic [15:0] mask;
    } match_cfg_t;
endpackage

// File: rtl/header_field_extract.sv
// header_field_extract: latches the two header bytes at the per-packet offset and performs the masked compare
module header_field_extract
    import header_capture_filter_pkg::*;
#(
    parameter int DATA_W = 64,
    parameter int KEEP_W = DATA_W / 8,
    parameter int N      = COUNT_META_DATA_MAX_DEF,
    parameter int CNT_W  = $clog2(N + 1),
    parameter int OFF_W  = $clog2(N * KEEP_W)
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              clear,
    input  logic              capture,
    input  logic [CNT_W-1:0]  count,
    input  logic [DATA_W-1:0] tdata,
    input  logic [KEEP_W-1:0] tkeep,
    input  match_cfg_t        cfg_live,
    input  logic [OFF_W-1:0]  offset_live,
    output logic              enable,
    output logic              drop_on_match,
    output logic              match
);
    localparam int LANE_W = $clog2(KEEP_W);

    match_cfg_t       cfg;
    logic [OFF_W-1:0] offset, off_eff;
    logic [OFF_W:0]   hi_idx, lo_idx;
    logic [15:0]      field;
    logic             hi_vld, lo_vld, first, in_range, hi_hit, lo_hit;

    assign first = capture && count == '0;
    // the first beat must use the live offset because the shadow loads on that same edge
    assign off_eff  = first ? offset_live : offset;
    assign hi_idx   = {1'b0, off_eff};
    assign lo_idx   = hi_idx + (OFF_W + 1)'(1);
    assign in_range = int'(off_eff) <= N * KEEP_W - 2;
    assign hi_hit   = capture && in_range && int'(hi_idx[OFF_W:LANE_W]) == int'(count) && tkeep[hi_idx[LANE_W-1:0]];
    assign lo_hit   = capture && in_range && int'(lo_idx[OFF_W:LANE_W]) == int'(count) && tkeep[lo_idx[LANE_W-1:0]];

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            cfg    <= '0;
            offset <= '0;
            field  <= '0;
            hi_vld <= 1'b0;
            lo_vld <= 1'b0;
        end else begin
            if (first) begin
                cfg    <= cfg_live;
                offset <= offset_live;
            end
            if (clear) begin
                hi_vld <= 1'b0;
                lo_vld <= 1'b0;
            end else begin
                if (hi_hit) begin
                    field[15:8] <= tdata[{hi_idx[LANE_W-1:0], 3'b000} +: 8];
                    hi_vld      <= 1'b1;
                end else if (first) begin
                    hi_vld <= 1'b0;
                end
                if (lo_hit) begin
                    field[7:0] <= tdata[{lo_idx[LANE_W-1:0], 3'b000} +: 8];
                    lo_vld     <= 1'b1;
                end else if (first) begin
                    lo_vld <= 1'b0;
                end
            end
        end
    end

    assign enable        = cfg.enable;
    assign drop_on_match = cfg.drop_on_match;
    assign match         = cfg.enable && hi_vld && lo_vld && ((field ^ cfg.value) & cfg.mask) == '0;
endmodule

// File: rtl/header_capture_filter.sv
// header_capture_filter: captures the leading beats of each packet, drives the drop decision
// and replays or passes through the stream under control of the dispatcher FSM state.
module header_capture_filter
    import header_capture_filter_pkg::*;
#(
    parameter int AXIS_DATA_WIDTH     = 64,
    parameter int AXIS_KEEP_WIDTH     = AXIS_DATA_WIDTH / 8,
    parameter int COUNT_META_DATA_MAX = COUNT_META_DATA_MAX_DEF,
    parameter int COUNTER_WIDTH       = $clog2(COUNT_META_DATA_MAX + 1),
    parameter int STATE_WIDTH         = STATE_WIDTH_DEF,
    parameter int OFFSET_WIDTH        = $clog2(COUNT_META_DATA_MAX * AXIS_KEEP_WIDTH)
) (
    input  logic                       clk,
    input  logic                       rst_n,
    input  logic [STATE_WIDTH-1:0]     state,
    input  logic [COUNTER_WIDTH-1:0]   count,
    input  logic [AXIS_DATA_WIDTH-1:0] s_axis_tdata,
    input  logic [AXIS_KEEP_WIDTH-1:0] s_axis_tkeep,
    input  logic                       s_axis_tvalid,
    input  logic                       s_axis_tready,
    output logic [AXIS_DATA_WIDTH-1:0] m_axis_tdata,
    output logic [AXIS_KEEP_WIDTH-1:0] m_axis_tkeep,
    output logic                       drop,
    input  logic                       cfg_match_enable,
    input  logic                       cfg_drop_on_match,
    input  logic [OFFSET_WIDTH-1:0]    cfg_match_offset,
    input  logic [15:0]                cfg_match_value,
    input  logic [15:0]                cfg_match_mask,
    input  logic                       rst_match_counter,
    output logic [31:0]                match_counter
);
    localparam int N = COUNT_META_DATA_MAX;

    logic [AXIS_DATA_WIDTH-1:0] beat_data [N];
    logic [AXIS_KEEP_WIDTH-1:0] beat_keep [N];
    match_cfg_t cfg_live;
    logic count_ok, capture, in_control, replay, remain, idle, match, enable, drop_on_match;

    assign count_ok   = int'(count) < N;
    assign capture    = state == PARSE_DATA && s_axis_tvalid && s_axis_tready;
    assign in_control = state == CONTROL;
    assign replay     = state == SEND_ANALYSED_DATA && count_ok;
    assign remain     = state == SEND_REMAIN;
    assign idle       = state == IDLE || state > DROP;
    assign cfg_live   = '{enable: cfg_match_enable, drop_on_match: cfg_drop_on_match,
                          value: cfg_match_value, mask: cfg_match_mask};

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int i = 0; i < N; i++) begin
                beat_data[i] <= '0;
                beat_keep[i] <= '0;
            end
        end else if (capture && count_ok) begin
            beat_data[count] <= s_axis_tdata;
            beat_keep[count] <= s_axis_tkeep;
        end
    end

    header_field_extract #(
        .DATA_W (AXIS_DATA_WIDTH),
        .KEEP_W (AXIS_KEEP_WIDTH),
        .N      (N),
        .CNT_W  (COUNTER_WIDTH),
        .OFF_W  (OFFSET_WIDTH)
    ) u_extract (
        .clk           (clk),
        .rst_n         (rst_n),
        .clear         (idle),
        .capture       (capture),
        .count         (count),
        .tdata         (s_axis_tdata),
        .tkeep         (s_axis_tkeep),
        .cfg_live      (cfg_live),
        .offset_live   (cfg_match_offset),
        .enable        (enable),
        .drop_on_match (drop_on_match),
        .match         (match)
    );

    assign drop = in_control && enable && (match == drop_on_match);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) match_counter <= '0;
        else if (rst_match_counter) match_counter <= '0;
        else if (in_control && match) match_counter <= match_counter + 32'd1;
    end

    assign m_axis_tdata = replay ? beat_data[count] : remain ? s_axis_tdata : '0;
    assign m_axis_tkeep = replay ? beat_keep[count] : remain ? s_axis_tkeep : '0;
endmodule

// File: tb/tb_header_capture_filter.sv
// tb_header_capture_filter: directed packets with hand-derived decisions; a negedge monitor checks a queue of expectations.
module tb_header_capture_filter;
    import header_capture_filter_pkg::*;

    typedef struct {
        int          id;
        logic        drop;
        logic [63:0] data;
        logic [7:0]  keep;
        logic [31:0] cnt;
    } exp_t;

    logic        clk = 1'b0;
    logic        rst_n;
    logic [2:0]  state, count;
    logic [63:0] s_axis_tdata, m_axis_tdata;
    logic [7:0]  s_axis_tkeep, m_axis_tkeep;
    logic        s_axis_tvalid, s_axis_tready, drop;
    logic        cfg_match_enable, cfg_drop_on_match, rst_match_counter;
    logic [5:0]  cfg_match_offset;
    logic [15:0] cfg_match_value, cfg_match_mask;
    logic [31:0] match_counter;

    exp_t        q[$];
    int          tests = 0, fails = 0, tid = 0;
    logic        probe = 1'b0;
    logic [31:0] exp_cnt = 0;
    logic [7:0]  pk [64];

    always #5 clk = ~clk;

    header_capture_filter dut (
        .clk(clk), .rst_n(rst_n), .state(state), .count(count),
        .s_axis_tdata(s_axis_tdata), .s_axis_tkeep(s_axis_tkeep),
        .s_axis_tvalid(s_axis_tvalid), .s_axis_tready(s_axis_tready),
        .m_axis_tdata(m_axis_tdata), .m_axis_tkeep(m_axis_tkeep), .drop(drop),
        .cfg_match_enable(cfg_match_enable), .cfg_drop_on_match(cfg_drop_on_match),
        .cfg_match_offset(cfg_match_offset), .cfg_match_value(cfg_match_value),
        .cfg_match_mask(cfg_match_mask), .rst_match_counter(rst_match_counter),
        .match_counter(match_counter)
    );

    always @(negedge clk) begin
        if (probe || state == CONTROL || state == SEND_ANALYSED_DATA || state == SEND_REMAIN || state == DROP) begin
            exp_t e;
            tests++;
            if (q.size() == 0) begin
                fails++;
                $display("FAIL t%0d no expectation queued for output in state %0d", tid, state);
            end else begin
                e = q.pop_front();
                if (drop !== e.drop || m_axis_tdata !== e.data || m_axis_tkeep !== e.keep || match_counter !== e.cnt) begin
                    fails++;
                    $display("FAIL t%0d got drop=%b data=%h keep=%h cnt=%0d, want drop=%b data=%h keep=%h cnt=%0d",
                             e.id, drop, m_axis_tdata, m_axis_tkeep, match_counter, e.drop, e.data, e.keep, e.cnt);
                end
            end
        end
    end

    function automatic logic [63:0] beat(input int i);
        logic [63:0] b;
        for (int l = 0; l < 8; l++) b[8*l +: 8] = pk[8*i + l];
        return b;
    endfunction

    function automatic logic [7:0] keep_of(input int i, input int nb, input logic [7:0] lk);
        return (i == nb - 1) ? lk : 8'hFF;
    endfunction

    task automatic fill(input int seed);
        for (int k = 0; k < 64; k++) pk[k] = 8'(k * 13 + seed + 1);
    endtask

    task automatic push(input logic d, input logic [63:0] data, input logic [7:0] keep, input logic [31:0] c);
        q.push_back('{tid, d, data, keep, c});
    endtask

    task automatic drive(input logic [2:0] st, input int c, input logic [63:0] d, input logic [7:0] k, input logic v);
        state = st; count = 3'(c); s_axis_tdata = d; s_axis_tkeep = k; s_axis_tvalid = v; s_axis_tready = v;
        @(posedge clk); #1;
    endtask

    task automatic set_cfg(input logic en, input logic dom, input int off, input logic [15:0] val, input logic [15:0] msk);
        cfg_match_enable = en; cfg_drop_on_match = dom; cfg_match_offset = 6'(off);
        cfg_match_value = val; cfg_match_mask = msk;
    endtask

    // em/ed are the hand-derived match and drop decisions for this packet
    task automatic send_pkt(input int nb, input logic [7:0] lk, input logic em, input logic ed,
                            input int chg_off, input logic rmc);
        int nc;
        nc = nb < 5 ? nb : 5;
        drive(IDLE, 0, 64'h0, 8'h0, 1'b0);
        for (int i = 0; i < nc; i++) begin
            if (i == 1 && chg_off >= 0) cfg_match_offset = 6'(chg_off);
            drive(PARSE_DATA, i, beat(i), keep_of(i, nb, lk), 1'b1);
        end
        rst_match_counter = rmc;
        push(ed, 64'h0, 8'h0, exp_cnt);
        drive(CONTROL, nc, 64'hDEAD_BEEF_0123_4567, 8'hFF, 1'b0);
        rst_match_counter = 1'b0;
        exp_cnt = rmc ? 32'd0 : exp_cnt + 32'(em);
        if (ed) begin
            for (int i = nc; i < (nb > nc ? nb : nc + 1); i++) begin
                push(1'b0, 64'h0, 8'h0, exp_cnt);
                drive(DROP, i, beat(i), keep_of(i, nb, lk), 1'b1);
            end
        end else begin
            for (int i = 0; i < nc; i++) begin
                push(1'b0, beat(i), keep_of(i, nb, lk), exp_cnt);
                drive(SEND_ANALYSED_DATA, i, ~beat(i), 8'h55, 1'b0);
            end
            for (int i = nc; i < nb; i++) begin
                push(1'b0, beat(i), keep_of(i, nb, lk), exp_cnt);
                drive(SEND_REMAIN, i, beat(i), keep_of(i, nb, lk), 1'b1);
            end
        end
    endtask

    initial begin
        rst_n = 1'b0; state = IDLE; count = 0; s_axis_tdata = 0; s_axis_tkeep = 0;
        s_axis_tvalid = 0; s_axis_tready = 0; rst_match_counter = 0;
        set_cfg(0, 0, 0, 16'h0, 16'h0);
        probe = 1'b1;
        push(1'b0, 64'h0, 8'h0, 32'd0);
        @(negedge clk); #1 probe = 1'b0;
        @(posedge clk); #1 rst_n = 1'b1;

        tid = 1; fill(1); pk[12] = 8'h08; pk[13] = 8'h00;
        set_cfg(1, 1, 12, 16'h0800, 16'hFFFF);
        send_pkt(8, 8'hFF, 1, 1, -1, 0);

        tid = 2; pk[12] = 8'h86; pk[13] = 8'hDD;
        send_pkt(8, 8'h3F, 0, 0, -1, 0);

        tid = 3; fill(3); pk[7] = 8'hAB; pk[8] = 8'h12;
        set_cfg(1, 0, 7, 16'hABCD, 16'hFF00);
        send_pkt(6, 8'hFF, 1, 0, -1, 0);

        tid = 4; set_cfg(1, 0, 20, 16'h0000, 16'h0000);
        send_pkt(2, 8'h0F, 0, 1, -1, 0);

        tid = 5; set_cfg(0, 0, 20, 16'h0000, 16'h0000);
        send_pkt(2, 8'h0F, 0, 0, -1, 0);
        push(1'b0, 64'h0, 8'h0, exp_cnt);
        drive(SEND_ANALYSED_DATA, 5, ~beat(0), 8'hFF, 1'b1);

        tid = 6; set_cfg(1, 1, 39, {pk[39], 8'h00}, 16'hFF00);
        send_pkt(5, 8'hFF, 0, 0, -1, 0);

        tid = 7; set_cfg(1, 1, 38, {pk[38], pk[39]}, 16'hFFFF);
        send_pkt(5, 8'hFF, 1, 1, -1, 0);

        tid = 8; fill(5); pk[12] = 8'h08; pk[13] = 8'h00; pk[20] = 8'h11; pk[21] = 8'h22;
        set_cfg(1, 1, 12, 16'h0800, 16'hFFFF);
        send_pkt(6, 8'hFF, 1, 1, 20, 0);

        tid = 9;
        send_pkt(6, 8'hFF, 0, 0, -1, 0);

        tid = 10; set_cfg(1, 1, 12, 16'h0800, 16'hFFFF);
        send_pkt(5, 8'hFF, 1, 1, -1, 1);

        tid = 11; set_cfg(1, 0, 12, 16'h0800, 16'hFFFF);
        send_pkt(5, 8'hFF, 1, 0, -1, 0);

        tid = 12;
        push(1'b0, beat(0), 8'hFF, exp_cnt);
        drive(SEND_ANALYSED_DATA, 0, 64'h0, 8'h0, 1'b0);
        rst_n = 1'b0; exp_cnt = 0;
        push(1'b0, 64'h0, 8'h0, 32'd0);
        drive(SEND_ANALYSED_DATA, 1, 64'h0, 8'h0, 1'b0);
        rst_n = 1'b1;
        drive(IDLE, 0, 64'h0, 8'h0, 1'b0);
        repeat (2) @(posedge clk);

        if (q.size() != 0) begin
            tests++;
            fails++;
            $display("FAIL leftover %0d expectations never matched by an output, want 0", q.size());
        end
        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end
endmodule
